// File: rtl/dmem_ctrl.sv
// dmem_ctrl: parametrised single-port data memory with valid/ready requests,
// a registered back-pressurable read response and a hardware clear sweep.
// Optional build macro DMEM_OOR_ERR_EN: out-of-range requests are flagged on
// o_rsp_err instead of wrapping modulo DEPTH.
module dmem_ctrl #(
   parameter int unsigned       DATA_W   = 16,
   parameter int unsigned       ADDR_W   = 16,
   parameter int unsigned       DEPTH    = 8192,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_clr_start,
   output logic                o_busy,
   input  logic                i_req_valid,
   output logic                o_req_ready,
   input  logic                i_req_we,
   input  logic [ADDR_W-1:0]   i_req_addr,
   input  logic [DATA_W-1:0]   i_req_wdata,
   input  logic [DATA_W/8-1:0] i_req_be,
   output logic                o_rsp_valid,
   input  logic                i_rsp_ready,
   output logic [DATA_W-1:0]   o_rsp_rdata
`ifdef DMEM_OOR_ERR_EN
   ,
   output logic                o_rsp_err
`endif
);

   localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned     NB       = DATA_W / 8;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   // One extra bit so DEPTH == 2**ADDR_W is representable.
   localparam logic [ADDR_W:0] DEPTH_A  = (ADDR_W + 1)'(DEPTH);

   typedef enum logic {StClear, StRun} state_t;

   logic [DATA_W-1:0] r_mem [DEPTH];
   state_t            r_state, w_state_nxt;
   logic [IDX_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic [IDX_W-1:0]  w_idx;
   logic              w_oor;
   logic              w_accept, w_rd_acc, w_wr_acc, w_deq;

   // Modulo folds any address into the array; a power-of-two DEPTH reduces to low bits.
   assign w_idx = IDX_W'({1'b0, i_req_addr} % DEPTH_A);

`ifdef DMEM_OOR_ERR_EN
   assign w_oor = ({1'b0, i_req_addr} >= DEPTH_A);
`else
   assign w_oor = 1'b0;
`endif

   assign o_busy      = (r_state == StClear);
   assign w_deq       = r_rsp_valid && i_rsp_ready;
   assign o_req_ready = (r_state == StRun) && !i_clr_start && (!r_rsp_valid || i_rsp_ready);
   assign w_accept    = i_req_valid && o_req_ready;
   assign w_rd_acc    = w_accept && !i_req_we;
   assign w_wr_acc    = w_accept && i_req_we;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_rdata = r_rsp_rdata;

   // State and sweep counter registers.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= StClear;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state: sweep every word once, then serve requests until a clear trigger.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         StClear: begin
            if (r_cnt == LAST_IDX) begin
               w_state_nxt = StRun;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         StRun: begin
            if (i_clr_start) begin
               w_state_nxt = StClear;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = StClear;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Memory array: sweep writes INIT_VAL, otherwise byte-masked request writes.
   always_ff @(posedge i_clk) begin
      if (r_state == StClear) begin
         r_mem[r_cnt] <= INIT_VAL;
      end else if (w_wr_acc && !w_oor) begin
         for (int k = 0; k < NB; k++) begin
            if (i_req_be[k]) begin
               r_mem[w_idx][8*k +: 8] <= i_req_wdata[8*k +: 8];
            end
         end
      end
   end

   // Response register: load on read accept, hold until dequeued, drop on clear.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else if (r_state == StClear || i_clr_start) begin
         r_rsp_valid <= 1'b0;
      end else if (w_rd_acc) begin
         r_rsp_valid <= 1'b1;
         r_rsp_rdata <= w_oor ? '0 : r_mem[w_idx];
      end else if (w_deq) begin
         // Data is kept on dequeue; only the valid flag falls.
         r_rsp_valid <= 1'b0;
      end
   end

`ifdef DMEM_OOR_ERR_EN
   logic r_rsp_err;

   // Error flag: follows a read response, or pulses one cycle for an out-of-range write.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_rsp_err <= 1'b0;
      end else if (r_state == StClear || i_clr_start) begin
         r_rsp_err <= 1'b0;
      end else if (w_accept) begin
         r_rsp_err <= w_oor;
      end else if (w_deq || !r_rsp_valid) begin
         r_rsp_err <= 1'b0;
      end
   end

   assign o_rsp_err = r_rsp_err;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl. Instance A uses DEPTH=16 and
// INIT_VAL=16'hA5A5; instance B uses DEPTH=12 to exercise non-power-of-two
// addressing. Both share the clock, reset and request inputs.
// Honours DMEM_OOR_ERR_EN when defined.
module tb_dmem_ctrl;

   logic        clk;
   logic        rst;
   logic        clr_start;
   logic        req_valid;
   logic        req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  req_be;
   logic        rsp_ready;

   logic        busy, req_ready, rsp_valid;
   logic [15:0] rsp_rdata;
   logic        b_busy, b_req_ready, b_rsp_valid;
   logic [15:0] b_rsp_rdata;
`ifdef DMEM_OOR_ERR_EN
   logic        rsp_err, b_rsp_err;
`endif

   int n_vec = 0;
   int n_err = 0;

   dmem_ctrl #(
      .DATA_W   (16),
      .ADDR_W   (16),
      .DEPTH    (16),
      .INIT_VAL (16'hA5A5)
   ) u_dut_a (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_clr_start (clr_start),
      .o_busy      (busy),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_we    (req_we),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
      .i_req_be    (req_be),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_rdata (rsp_rdata)
`ifdef DMEM_OOR_ERR_EN
      ,
      .o_rsp_err   (rsp_err)
`endif
   );

   dmem_ctrl #(
      .DATA_W   (16),
      .ADDR_W   (16),
      .DEPTH    (12),
      .INIT_VAL (16'h0000)
   ) u_dut_b (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_clr_start (clr_start),
      .o_busy      (b_busy),
      .i_req_valid (req_valid),
      .o_req_ready (b_req_ready),
      .i_req_we    (req_we),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
      .i_req_be    (req_be),
      .o_rsp_valid (b_rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_rdata (b_rsp_rdata)
`ifdef DMEM_OOR_ERR_EN
      ,
      .o_rsp_err   (b_rsp_err)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one request, wait (bounded) for acceptance, then withdraw it.
   task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [1:0] be);
      int guard;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      guard     = 0;
      #1;
      while (!req_ready && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check_eq("req_accept", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic rd(input logic [15:0] addr, output logic [15:0] da, output logic [15:0] db);
      issue(1'b0, addr, 16'h0, 2'b00);
      check_eq("rd_valid_a", {31'b0, rsp_valid}, 32'd1);
      check_eq("rd_valid_b", {31'b0, b_rsp_valid}, 32'd1);
      da = rsp_rdata;
      db = b_rsp_rdata;
   endtask

   // Count cycles with instance A busy, starting from the current sample point.
   task automatic wait_sweep(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [15:0] da, db;
      int          n;

      rst       = 1'b0;
      clr_start = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      rsp_ready = 1'b1;

      // Reset state
      #2;
      check_eq("rst_busy", {31'b0, busy}, 32'd1);
      check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check_eq("rst_rsp_rdata", {16'b0, rsp_rdata}, 32'd0);
      check_eq("rst_req_ready", {31'b0, req_ready}, 32'd0);

      // Sweep timing and contents
      @(posedge clk);
      #1;
      rst = 1'b1;
      wait_sweep(n);
      check_eq("sweep_cycles", n, 32'd16);
      check_eq("sweep_b_done", {31'b0, b_busy}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         rd(16'(i), da, db);
         check_eq("sweep_word", {16'b0, da}, 32'h0000A5A5);
      end

      // Byte enables, including an all-zero mask
      issue(1'b1, 16'd3, 16'h1234, 2'b11);
      issue(1'b1, 16'd3, 16'hFF00, 2'b10);
      rd(16'd3, da, db);
      check_eq("be_merge", {16'b0, da}, 32'h0000FF34);
      issue(1'b1, 16'd3, 16'hDEAD, 2'b00);
      rd(16'd3, da, db);
      check_eq("be_zero", {16'b0, da}, 32'h0000FF34);

      // Back-pressure hold, then dequeue and issue in the same cycle
      issue(1'b1, 16'd1, 16'h0021, 2'b11);
      issue(1'b1, 16'd2, 16'h0042, 2'b11);
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 16'd1;
      #1;
      check_eq("bp_first_ready", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_addr = 16'd2;
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
         check_eq("bp_hold_data", {16'b0, rsp_rdata}, 32'h00000021);
         check_eq("bp_hold_ready", {31'b0, req_ready}, 32'd0);
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      #1;
      check_eq("bp_release_ready", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      check_eq("bp_next_valid", {31'b0, rsp_valid}, 32'd1);
      check_eq("bp_next_data", {16'b0, rsp_rdata}, 32'h00000042);
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      check_eq("deq_valid_low", {31'b0, rsp_valid}, 32'd0);
      check_eq("deq_data_kept", {16'b0, rsp_rdata}, 32'h00000042);

      // Clear trigger
      for (int i = 0; i < 16; i++) begin
         issue(1'b1, 16'(i), 16'(i * 3), 2'b11);
      end
      rd(16'd5, da, db);
      check_eq("fill_word5", {16'b0, da}, 32'd15);
      clr_start = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 16'd0;
      req_wdata = 16'h1234;
      req_be    = 2'b11;
      #1;
      check_eq("clr_ready_low", {31'b0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      clr_start = 1'b0;
      req_valid = 1'b0;
      wait_sweep(n);
      check_eq("clr_cycles", n, 32'd16);
      for (int i = 0; i < 16; i++) begin
         rd(16'(i), da, db);
         check_eq("clr_word", {16'b0, da}, 32'h0000A5A5);
      end

      // Asynchronous reset in the middle of a read burst
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 16'd4;
      @(posedge clk);
      #1;
      check_eq("burst_valid", {31'b0, rsp_valid}, 32'd1);
      req_addr = 16'd5;
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check_eq("arst_valid", {31'b0, rsp_valid}, 32'd0);
      check_eq("arst_rdata", {16'b0, rsp_rdata}, 32'd0);
      check_eq("arst_busy", {31'b0, busy}, 32'd1);
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      wait_sweep(n);
      check_eq("arst_sweep_cycles", n, 32'd16);

      // Non-power-of-two depth addressing (instance B, DEPTH=12)
      issue(1'b1, 16'd1, 16'h1111, 2'b11);
      issue(1'b1, 16'd13, 16'hBEEF, 2'b11);
`ifdef DMEM_OOR_ERR_EN
      check_eq("oor_wr_err_pulse", {31'b0, b_rsp_err}, 32'd1);
      check_eq("oor_wr_no_valid", {31'b0, b_rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
      check_eq("oor_wr_err_end", {31'b0, b_rsp_err}, 32'd0);
`endif
      rd(16'd1, da, db);
      check_eq("a_addr1", {16'b0, da}, 32'h00001111);
`ifdef DMEM_OOR_ERR_EN
      check_eq("b_addr1_kept", {16'b0, db}, 32'h00001111);
      check_eq("b_addr1_err", {31'b0, b_rsp_err}, 32'd0);
`else
      check_eq("b_addr1_wrap", {16'b0, db}, 32'h0000BEEF);
`endif
      rd(16'd25, da, db);
`ifdef DMEM_OOR_ERR_EN
      check_eq("a_addr25_oor", {16'b0, da}, 32'd0);
      check_eq("a_addr25_err", {31'b0, rsp_err}, 32'd1);
      check_eq("b_addr25_oor", {16'b0, db}, 32'd0);
      check_eq("b_addr25_err", {31'b0, b_rsp_err}, 32'd1);
`else
      check_eq("a_addr25_wrap", {16'b0, da}, 32'h0000A5A5);
      check_eq("b_addr25_wrap", {16'b0, db}, 32'h0000BEEF);
`endif
      rd(16'd12, da, db);
      check_eq("a_addr12", {16'b0, da}, 32'h0000A5A5);
      check_eq("b_addr12", {16'b0, db}, 32'd0);
`ifdef DMEM_OOR_ERR_EN
      check_eq("b_addr12_err", {31'b0, b_rsp_err}, 32'd1);
      check_eq("a_addr12_err", {31'b0, rsp_err}, 32'd0);
`endif

      @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised single-port data memory with a valid/ready request channel and a registered, back-pressurable read-response channel.
- After reset, or on a software trigger, a hardware sweep FSM clears every word to INIT_VAL.
- Serves as the data-memory block for the RSA encoder/decoder datapath.
- Adds to the earlier fixed 16-bit data memory: configurable width and depth, byte enables, a clear sequencer, and flow control.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- ADDR_W, 16, request address width.
- DEPTH, 8192, number of words; 2 <= DEPTH <= 2^ADDR_W; need not be a power of two.
- INIT_VAL, 0, value written to every word by the clear sweep.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr_start  in  1  one-cycle request to re-run the clear sweep; honoured only in RUN.
- busy  out  1  high while the clear sweep runs.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables for writes; bit k covers bits [8k+7:8k].
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  out-of-range flag; exists only with DMEM_OOR_ERR_EN.

Behaviour:
- Reset (rst low, asynchronous):
  - state = CLEAR, clear counter = 0, busy = 1.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - The memory array itself is not reset; the sweep initialises it.
- FSM has two states, CLEAR and RUN.
- CLEAR:
  - Writes INIT_VAL to word[counter] each cycle, then increments the counter.
  - When the write to DEPTH-1 completes, goes to RUN; busy falls on that edge.
  - A full sweep takes exactly DEPTH cycles after rst rises.
  - req_ready = 0 throughout. Request inputs are ignored. rsp_valid is forced to 0 on entry.
- RUN:
  - clr_start = 1 moves to CLEAR on the next edge with the counter reset to 0.
  - req_ready is combinationally 0 in the cycle clr_start is high.
  - A response pending when CLEAR is entered is dropped (rsp_valid cleared).
- req_ready = (state == RUN) && !clr_start && (!rsp_valid || rsp_ready).
- Write accepted at edge N:
  - Only enabled bytes of word[addr] are updated.
  - req_be = 0 is legal and changes nothing.
  - No response is produced.
  - The new data is visible to a read accepted at edge N+1 or later.
- Read accepted at edge N:
  - rsp_valid = 1 and rsp_rdata = word[addr] from edge N, giving 1-cycle latency.
  - Both hold stable until rsp_valid && rsp_ready.
- Response dequeue and issue:
  - A read may be accepted in the same cycle the pending response is dequeued. This gives back-to-back reads at one per cycle when rsp_ready is held high.
  - On a dequeue with no new read, rsp_valid falls. rsp_rdata keeps its last value; it is not zeroed.
- Addressing:
  - Without the optional feature, the effective address is req_addr modulo DEPTH.
  - For power-of-two DEPTH this is the low clog2(DEPTH) bits.
- Outputs are driven from registers except req_ready.

Optional Feature:
- Macro: DMEM_OOR_ERR_EN.
- Defined:
  - A request with req_addr >= DEPTH is still accepted normally.
  - An out-of-range write is dropped and the memory is unchanged.
  - An out-of-range read returns rsp_rdata = 0 with rsp_err = 1, valid and held with rsp_valid.
  - An in-range read returns rsp_err = 0.
  - An out-of-range write additionally raises rsp_err as a one-cycle pulse with rsp_valid = 0.
- Not defined: no rsp_err port; addresses wrap modulo DEPTH.

Test Plan:
- Sweep timing: DEPTH=16, INIT_VAL=16'hA5A5, rst released at cycle 0 -> busy high for exactly 16 cycles; read of addr 0..15 returns 16'hA5A5.
- Byte-enable write then read: write addr 3 = 16'h1234 with be=2'b11, then addr 3 = 16'hFF00 with be=2'b10, then read addr 3 -> rsp_rdata = 16'hFF34 one cycle after acceptance.
- Back-pressure: read addr 1 (=16'h0021) with rsp_ready=0 for 5 cycles -> rsp_valid and data held, req_ready=0; raise rsp_ready -> dequeue and a new read of addr 2 issues in the same cycle.
- Clear trigger: fill addr 0..15 with addr*3, pulse clr_start with req_valid=1 -> that request is not accepted; busy for 16 cycles; all words read INIT_VAL.
- Async reset during back-to-back reads: drop rst mid-burst -> rsp_valid=0 and rsp_rdata=0 immediately without a clock; the sweep restarts.
- With DMEM_OOR_ERR_EN, DEPTH=12: read addr 12 -> rsp_rdata=0 with rsp_err=1; write 16'hBEEF to addr 13 -> addr 1 unchanged. Without the macro: the write lands at addr 1.
